// File: rtl/dac_spi_tx.sv
// Serialises 10-bit DAC codes into 16-bit MCP4911-style SPI write frames (mode 0),
// strobes LDAC after each frame, and keeps one pending sample for mid-frame loads.
`timescale 1ns/1ps
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 25,
    parameter logic [3:0]  CTRL    = 4'b0111
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       busy,
    output logic       overrun,
    output logic       frame_done,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [9:0]       pend_data;
    logic             pend_valid;
    logic [14:0]      shift_reg;

    logic             phase_end;
    logic             start;
    logic             sck_fall;
    logic [15:0]      frame_word;

    always_comb begin
        phase_end  = (div_cnt == DIV_LAST);
        start      = (state == IDLE) && (load || pend_valid);
        sck_fall   = (state == SHIFT) && phase_end && dac_sck;
        frame_word = {CTRL, (load ? data_in : pend_data), 2'b00};
    end

    // Bit 15 goes straight to dac_sdi at frame start, so only the remaining 15 bits are held here.
    always_ff @(posedge sysclk) begin
        if (start)
            shift_reg <= frame_word[14:0];
        else if (sck_fall)
            shift_reg <= {shift_reg[13:0], 1'b0};
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sck    <= 1'b0;
            dac_sdi    <= 1'b0;
            dac_ld_n   <= 1'b1;
        end else begin
            overrun    <= 1'b0;
            frame_done <= 1'b0;

            // IDLE always consumes the pending slot; a direct load there supersedes it.
            if (state == IDLE) begin
                pend_valid <= 1'b0;
                overrun    <= load && pend_valid;
            end else if (load) begin
                pend_data  <= data_in;
                pend_valid <= 1'b1;
                overrun    <= pend_valid;
            end

            if (state == IDLE || phase_end)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        dac_cs_n <= 1'b0;
                        dac_sdi  <= frame_word[15];
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (!dac_sck) begin
                            dac_sck <= 1'b1;
                        end else begin
                            dac_sck <= 1'b0;
                            dac_sdi <= shift_reg[14];
                            if (bit_cnt == 5'd15)
                                state <= HOLD;
                            else
                                bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        dac_cs_n <= 1'b1;
                        dac_ld_n <= 1'b0;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        dac_ld_n   <= 1'b1;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (CLK_DIV 2, 1, 25) watched by a pin-level frame
// monitor and compared against a load-timestamp model of frame starts and overruns.
`timescale 1ns/1ps
module tb_dac_spi_tx;

    localparam logic [6:0] RST_OUTS = 7'b0001001;  // busy,overrun,frame_done,cs_n,sck,sdi,ld_n

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] load_v = '0;
    logic [9:0] data_v [3];
    logic [2:0] busy_v, overrun_v, fd_v, cs_v, sck_v, sdi_v, ld_v;

    dac_spi_tx #(.CLK_DIV(2)) u_div2 (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_v[0]), .load(load_v[0]),
        .busy(busy_v[0]), .overrun(overrun_v[0]), .frame_done(fd_v[0]),
        .dac_cs_n(cs_v[0]), .dac_sck(sck_v[0]), .dac_sdi(sdi_v[0]), .dac_ld_n(ld_v[0]));

    dac_spi_tx #(.CLK_DIV(1)) u_div1 (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_v[1]), .load(load_v[1]),
        .busy(busy_v[1]), .overrun(overrun_v[1]), .frame_done(fd_v[1]),
        .dac_cs_n(cs_v[1]), .dac_sck(sck_v[1]), .dac_sdi(sdi_v[1]), .dac_ld_n(ld_v[1]));

    dac_spi_tx #(.CLK_DIV(25)) u_div25 (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_v[2]), .load(load_v[2]),
        .busy(busy_v[2]), .overrun(overrun_v[2]), .frame_done(fd_v[2]),
        .dac_cs_n(cs_v[2]), .dac_sck(sck_v[2]), .dac_sdi(sdi_v[2]), .dac_ld_n(ld_v[2]));

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor state and per-frame records
    logic [2:0] pcs, psck, psdi, pld, pbusy;
    int csf[3], acc[3], nb[3], cslen[3], first[3], lastfall[3], ldf[3], lowrun[3], hirun[3];
    int nfr[3], rises[3], nldf[3], nldr[3], nbf[3], ngap[3], ovr_cnt[3], ovr_last[3], viol[3], fdc[3];
    int fr_start[3][64], fr_word[3][64], fr_nbits[3][64], fr_cslen[3][64], fr_setup[3][64];
    int fr_hold[3][64], fr_ldoff[3][64], fr_ldlen[3][64], fr_fd[3][64], fr_busyhi[3][64], fr_gap[3][64];

    // Stimulus log and model output
    int         ld_cyc[$];
    logic [9:0] ld_dat[$];
    int         m_start[$];
    logic [9:0] m_data[$];
    int         m_ovr;
    int s_fr, s_ovr, s_fdc, s_ldf, s_ldr, s_bf, s_gap, s_viol;

    initial begin
        forever begin
            @(negedge sysclk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    nfr[i] = 0; rises[i] = 0; nldf[i] = 0; nldr[i] = 0; nbf[i] = 0; ngap[i] = 0;
                    ovr_cnt[i] = 0; ovr_last[i] = -1; viol[i] = 0; fdc[i] = 0;
                    lowrun[i] = 0; hirun[i] = 0; first[i] = -1; csf[i] = 0; lastfall[i] = 0; ldf[i] = 0;
                    pcs[i] = 1'b1; psck[i] = 1'b0; psdi[i] = 1'b0; pld[i] = 1'b1; pbusy[i] = 1'b0;
                end else begin
                    if (!cs_v[i] && pcs[i]) begin
                        csf[i] = cyc; acc[i] = 0; nb[i] = 0; cslen[i] = 0; first[i] = -1;
                    end
                    if (!cs_v[i]) cslen[i]++;
                    if (sck_v[i] && !psck[i]) begin
                        rises[i]++;
                        if (cs_v[i]) viol[i]++;
                        acc[i] = (acc[i] << 1) | int'(sdi_v[i]);
                        nb[i]++;
                        if (first[i] < 0) first[i] = cyc - csf[i];
                    end
                    if (!sck_v[i] && psck[i]) lastfall[i] = cyc;
                    if (sck_v[i] && (sdi_v[i] != psdi[i])) viol[i]++;
                    if (cs_v[i] && !pcs[i]) begin
                        if (nfr[i] < 64) begin
                            fr_start[i][nfr[i]] = csf[i];
                            fr_word[i][nfr[i]]  = acc[i] & 32'hFFFF;
                            fr_nbits[i][nfr[i]] = nb[i];
                            fr_cslen[i][nfr[i]] = cslen[i];
                            fr_setup[i][nfr[i]] = first[i];
                            fr_hold[i][nfr[i]]  = cyc - lastfall[i];
                        end
                        nfr[i]++;
                    end
                    if (!ld_v[i] && pld[i]) begin
                        ldf[i] = cyc;
                        if (nldf[i] < 64) fr_ldoff[i][nldf[i]] = cyc - csf[i];
                        nldf[i]++;
                    end
                    if (ld_v[i] && !pld[i]) begin
                        if (nldr[i] < 64) begin
                            fr_ldlen[i][nldr[i]] = cyc - ldf[i];
                            fr_fd[i][nldr[i]]    = int'(fd_v[i]);
                        end
                        nldr[i]++;
                    end
                    if (busy_v[i] && !pbusy[i]) begin
                        if (ngap[i] < 64) fr_gap[i][ngap[i]] = lowrun[i];
                        ngap[i]++;
                        hirun[i] = 0;
                    end
                    if (!busy_v[i] && pbusy[i]) begin
                        if (nbf[i] < 64) fr_busyhi[i][nbf[i]] = hirun[i];
                        nbf[i]++;
                        lowrun[i] = 0;
                    end
                    if (busy_v[i]) hirun[i]++; else lowrun[i]++;
                    if (fd_v[i]) fdc[i]++;
                    if (overrun_v[i]) begin
                        ovr_cnt[i]++;
                        ovr_last[i] = cyc;
                    end
                    pcs[i] = cs_v[i]; psck[i] = sck_v[i]; psdi[i] = sdi_v[i];
                    pld[i] = ld_v[i]; pbusy[i] = busy_v[i];
                end
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int i, input string tag);
        check($sformatf("%s.outs%0d", tag, i),
              int'({busy_v[i], overrun_v[i], fd_v[i], cs_v[i], sck_v[i], sdi_v[i], ld_v[i]}),
              int'(RST_OUTS));
    endtask

    // Called at a negedge; load is sampled by the DUT on the next rising edge.
    task automatic pulse(input int i, input logic [9:0] d);
        load_v[i] = 1'b1;
        data_v[i] = d;
        ld_cyc.push_back(cyc + 1);
        ld_dat.push_back(d);
        @(negedge sysclk);
        load_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic begin_test(input int i);
        s_fr = nfr[i]; s_ovr = ovr_cnt[i]; s_fdc = fdc[i]; s_ldf = nldf[i]; s_ldr = nldr[i];
        s_bf = nbf[i]; s_gap = ngap[i]; s_viol = viol[i];
        ld_cyc.delete();
        ld_dat.delete();
        @(negedge sysclk);
    endtask

    // Frame start times from load timestamps: a frame occupies 35*d cycles and the
    // block is idle again one cycle later; loads before that go to the one-deep slot.
    task automatic model_run(input int d);
        int         next_idle;
        bit         pv;
        logic [9:0] pd;
        m_start.delete();
        m_data.delete();
        m_ovr = 0;
        next_idle = -1000000;
        pv = 1'b0;
        pd = '0;
        foreach (ld_cyc[k]) begin
            if (pv && next_idle < ld_cyc[k]) begin
                m_start.push_back(next_idle);
                m_data.push_back(pd);
                pv = 1'b0;
                next_idle = next_idle + 35 * d + 1;
            end
            if (ld_cyc[k] >= next_idle) begin
                if (pv) m_ovr++;
                pv = 1'b0;
                m_start.push_back(ld_cyc[k]);
                m_data.push_back(ld_dat[k]);
                next_idle = ld_cyc[k] + 35 * d + 1;
            end else begin
                if (pv) m_ovr++;
                pv = 1'b1;
                pd = ld_dat[k];
            end
        end
        if (pv) begin
            m_start.push_back(next_idle);
            m_data.push_back(pd);
        end
    endtask

    task automatic verify(input int i, input int d, input string tag);
        int nexp;
        #2;
        model_run(d);
        nexp = m_start.size();
        check({tag, ".frames"}, nfr[i] - s_fr, nexp);
        check({tag, ".overruns"}, ovr_cnt[i] - s_ovr, m_ovr);
        check({tag, ".frame_done_pulses"}, fdc[i] - s_fdc, nexp);
        check({tag, ".ldac_pulses"}, nldr[i] - s_ldr, nexp);
        check({tag, ".mode0_violations"}, viol[i] - s_viol, 0);
        for (int k = 0; k < nexp; k++) begin
            int f, lf, lr, b;
            f = s_fr + k; lf = s_ldf + k; lr = s_ldr + k; b = s_bf + k;
            if (f < nfr[i] && f < 64) begin
                check($sformatf("%s.start[%0d]", tag, k), fr_start[i][f], m_start[k]);
                check($sformatf("%s.word[%0d]", tag, k), fr_word[i][f], (7 << 12) | (int'(m_data[k]) << 2));
                check($sformatf("%s.sck_rises[%0d]", tag, k), fr_nbits[i][f], 16);
                check($sformatf("%s.cs_low[%0d]", tag, k), fr_cslen[i][f], 34 * d);
                check($sformatf("%s.cs_setup[%0d]", tag, k), fr_setup[i][f], 2 * d);
                check($sformatf("%s.cs_hold[%0d]", tag, k), fr_hold[i][f], d);
            end
            if (lf < nldf[i] && lf < 64)
                check($sformatf("%s.ld_fall_ofs[%0d]", tag, k), fr_ldoff[i][lf], 34 * d);
            if (lr < nldr[i] && lr < 64) begin
                check($sformatf("%s.ld_low[%0d]", tag, k), fr_ldlen[i][lr], d);
                check($sformatf("%s.done_at_ld_rise[%0d]", tag, k), fr_fd[i][lr], 1);
            end
            if (b < nbf[i] && b < 64)
                check($sformatf("%s.busy_high[%0d]", tag, k), fr_busyhi[i][b], 35 * d);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data_v[i] = '0;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 3; i++) check_outs(i, "reset");
        @(posedge sysclk);
        #1 rst_n = 1'b1;

        // Reset mid-SHIFT with a sample pending: nothing may follow the release.
        begin_test(0);
        pulse(0, 10'h2A5);
        idle(4);
        pulse(0, 10'h0FF);
        idle(15);
        #2 rst_n = 1'b0;
        #1 check_outs(0, "async_rst");
        @(negedge sysclk);
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        @(negedge sysclk);
        idle(200);
        #2;
        check("post_rst.sck_rises", rises[0], 0);
        check("post_rst.ld_falls", nldf[0], 0);
        check("post_rst.frames", nfr[0], 0);
        check_outs(0, "post_rst");

        begin_test(0);
        pulse(0, 10'h2A5);
        idle(100);
        verify(0, 2, "single");
        check("single.word_const", fr_word[0][s_fr], 32'h7A94);

        begin_test(0);
        pulse(0, 10'h2A5);
        idle(19);
        pulse(0, 10'h0FF);
        idle(160);
        verify(0, 2, "pending");
        check("pending.word2_const", fr_word[0][s_fr + 1], 32'h73FC);

        begin_test(0);
        pulse(0, 10'h001);
        idle(9);
        pulse(0, 10'h002);
        idle(9);
        pulse(0, 10'h003);
        idle(160);
        verify(0, 2, "overrun");
        check("overrun.count", ovr_cnt[0] - s_ovr, 1);
        check("overrun.cycle", ovr_last[0], ld_cyc[2]);

        begin_test(1);
        for (int n = 0; n < 40; n++) begin
            pulse(1, 10'($urandom));
            idle(int'($urandom_range(0, 50)));
        end
        idle(100);
        verify(1, 1, "rand_div1");

        begin_test(2);
        for (int n = 0; n < 8; n++) begin
            pulse(2, 10'($urandom));
            idle(4999);
        end
        verify(2, 25, "b2b_div25");
        check("b2b_div25.overruns_abs", ovr_cnt[2] - s_ovr, 0);
        for (int k = 1; k < 8; k++) begin
            int g;
            g = (s_gap + k < 64) ? fr_gap[2][s_gap + k] : -1;
            checks++;
            assert (g >= 4124) else begin
                errors++;
                $error("FAIL b2b_div25.busy_gap[%0d] observed=%0d expected>=4124", k, g);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream stage of the audio processor. Takes the registered 10-bit DAC code and its sample strobe, and serialises each sample into a 16-bit SPI write frame for an MCP4911-class 10-bit DAC.
- Pulses LDAC after each frame so the analogue output updates once per sample.
- Holds one pending sample so a strobe that arrives mid-frame is not lost.

Parameters:
- CLK_DIV, 25: sysclk cycles per SCK half-period. Legal minimum 1. 50 MHz gives 1 MHz SCK.
- CTRL, 4'b0111: frame bits [15:12] = ~A/B, BUF, ~GA, ~SHDN.

Ports:
- sysclk  in  1: system clock; all logic is on its rising edge.
- rst_n  in  1: asynchronous reset, active-low.
- data_in  in  10: DAC code (offset binary), sampled when load=1.
- load  in  1: one-cycle sample strobe (data_valid of the sample path).
- busy  out  1: high from the cycle after an accepted load until the return to IDLE.
- overrun  out  1: one-cycle pulse when a pending sample is overwritten.
- frame_done  out  1: one-cycle pulse on the cycle LDAC is released.
- dac_cs_n  out  1: SPI chip select, active-low.
- dac_sck  out  1: SPI clock, mode 0 (idle low, DAC samples on rising edge).
- dac_sdi  out  1: SPI data, MSB first; changes only while SCK is low.
- dac_ld_n  out  1: DAC latch strobe, active-low.

Behaviour:
- Reset (async, any state): state=IDLE, cs_n=1, sck=0, sdi=0, ld_n=1, busy=0, overrun=0, frame_done=0. Pending register is cleared and the divider is 0. A frame in progress is abandoned; no partial LDAC is issued.
- Frame word = {CTRL, data, 2'b00}, 16 bits, shifted MSB first.
- Tick: the divider counts 0..CLK_DIV-1. It clears on every state entry, so each phase below lasts exactly CLK_DIV cycles.
- IDLE: start a frame if load=1 or pending_valid=1.
  - Direct load takes priority over an older pending sample; the pending sample is discarded and overrun pulses.
  - On start: shift register <= frame word; cs_n<=0, sdi<=bit15 on the same edge; busy<=1; go to SETUP.
- SETUP: one phase, SCK low. Then go to SHIFT.
- SHIFT: 16 bits; each bit is one low phase then one high phase.
  - SCK rises at the start of the high phase.
  - At the end of the high phase SCK falls and sdi advances to the next bit on the same edge.
  - A 5-bit bit counter runs 0..15. After the 16th high phase go to HOLD with SCK low.
- HOLD: one phase, SCK low, cs_n still 0. At the end: cs_n<=1, ld_n<=0, go to LATCH.
- LATCH: one phase with ld_n=0. At the end: ld_n<=1, frame_done<=1 for one cycle, busy<=0, go to IDLE.
  - If pending_valid=1, the next frame starts on the following cycle; cs_n stays high for at least 1 cycle.
- Timing:
  - cs_n low for exactly 34*CLK_DIV cycles.
  - Full frame is 35*CLK_DIV cycles plus 1 IDLE cycle.
  - First SCK rise is 2*CLK_DIV cycles after cs_n falls.
- load while busy=1: data is captured into the pending register and pending_valid<=1.
  - If pending_valid was already 1, the new data overwrites it and overrun pulses for 1 cycle. Newest sample wins.
- load on the same cycle the FSM returns to IDLE is treated as load while busy (goes to pending). It is never dropped.
- The active frame's shift register is never modified mid-frame.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT with CLK_DIV=2 -> all outputs immediately at their reset values. After release, no SCK edges and no ld_n pulse until the next load.
- Single frame, CLK_DIV=2, data_in=10'h2A5 -> bits captured on SCK rising edges = 0111_1010100101_00; exactly 16 rising edges; cs_n low 68 cycles; ld_n low 2 cycles after cs_n rises; frame_done one pulse.
- Pending: second load (10'h0FF) 20 cycles into a frame -> second frame starts right after the first frame_done with payload 0111_0011111111_00; overrun stays 0.
- Overrun: three loads (10'h001, 10'h002, 10'h003) within one frame -> frame for 001 completes, next frame carries 003, and overrun pulses exactly once, on the cycle 003 is loaded.
- Mode-0 check, CLK_DIV=1 and CLK_DIV=25 -> sdi never changes while sck=1; cs_n setup and hold ≥ CLK_DIV cycles around the SCK edges.
- Back-to-back sample rate, CLK_DIV=25, load every 5000 cycles for 8 samples -> 8 frames, busy low ≥ 4124 cycles between frames, no overrun.
